// File: rtl/sha512_pad_2.sv
// ---------------------------------------------------------------------------
// sha512_pad_2
// Message front end for the two-chunk SHA-512 compressor. Collects a message
// byte stream into a 2048-bit buffer, appends the 0x80 marker byte and the
// 128-bit big-endian bit length, and presents the padded result as two
// 1024-bit chunks. Only messages that pad to exactly two chunks
// (MIN_LEN..MAX_LEN bytes) are accepted; any other length pulses err and the
// message is discarded.
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   in_data    message byte
//   in_valid   in_data is valid
//   in_last    in_data is the final message byte (qualified by in_valid)
//   in_ready   block accepts a byte this cycle
//   chunk0     first padded chunk, message byte 0 at bits [1023:1016]
//   chunk1     second padded chunk, bit length at bits [127:0]
//   out_valid  chunk0/chunk1 complete and stable
//   out_ready  consumer takes the chunks
//   err        one-cycle pulse: illegal message length, message discarded
// ---------------------------------------------------------------------------
module sha512_pad_2 #(
   parameter int MIN_LEN = 112,
   parameter int MAX_LEN = 239
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [1023:0] chunk0,
   output logic [1023:0] chunk1,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          err
);

   typedef enum logic [2:0] {
      IDLE,
      PAD,
      OUT,
      DRAIN,
      ERR
   } state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [2047:0] msg_buf;
   logic [10:0]   byte_lsb;

   // Byte k occupies msg_buf[2047-8k -: 8]; its low bit is 8*(255-k),
   // which is simply the inverted byte index shifted left by three.
   assign byte_lsb = {~cnt, 3'b000};

   assign chunk0 = msg_buf[2047:1024];
   assign chunk1 = msg_buf[1023:0];

   // Single state machine: collects bytes, pads, holds the chunks until the
   // consumer takes them, and swallows overlong messages in DRAIN. All
   // handshake outputs are registered and updated together with the state.
   // The buffer is cleared on every path back to IDLE, so the zero fill
   // between the 0x80 marker and the length field never needs writing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         msg_buf   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // A non-final byte once MAX_LEN bytes are held means
                  // overflow; that byte is dropped and the rest drained.
                  if (!in_last && cnt == 8'(MAX_LEN)) begin
                     state <= DRAIN;
                  end else begin
                     msg_buf[byte_lsb +: 8] <= in_data;
                     cnt                    <= cnt + 8'd1;
                     if (in_last) begin
                        state    <= PAD;
                        in_ready <= 1'b0;
                     end
                  end
               end
            end

            PAD: begin
               // A final byte arriving at cnt==MAX_LEN gives a length one
               // past the legal range, so the upper bound is checked too.
               if (cnt < 8'(MIN_LEN) || cnt > 8'(MAX_LEN)) begin
                  state <= ERR;
                  err   <= 1'b1;
               end else begin
                  msg_buf[byte_lsb +: 8] <= 8'h80;
                  msg_buf[127:0]         <= {117'd0, cnt, 3'b000};
                  state                  <= OUT;
                  out_valid              <= 1'b1;
               end
            end

            OUT: begin
               if (out_valid && out_ready) begin
                  msg_buf   <= '0;
                  cnt       <= 8'd0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            DRAIN: begin
               if (in_valid && in_ready && in_last) begin
                  state    <= ERR;
                  err      <= 1'b1;
                  in_ready <= 1'b0;
               end
            end

            ERR: begin
               msg_buf  <= '0;
               cnt      <= 8'd0;
               in_ready <= 1'b1;
               state    <= IDLE;
            end

            default: begin
               state     <= IDLE;
               cnt       <= 8'd0;
               msg_buf   <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
